// File: rtl/shift_add_multiplier_32bit_if.sv
// Start/Busy/Done handshake and operand/result bus of the sequential shift-add multiplier.
// The master drives the request side; the multiplier sits on the slave modport.
interface shift_add_multiplier_32bit_if;
  logic        Start;
  logic        Signed;
  logic [31:0] Multiplicand;
  logic [31:0] Multiplier;
  logic [63:0] Product;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Signed, Multiplicand, Multiplier,
    input  Product, Busy, Done
  );

  modport slave (
    input  Start, Signed, Multiplicand, Multiplier,
    output Product, Busy, Done
  );
endinterface

// File: rtl/shift_add_multiplier_32bit.sv
// Sequential 32x32->64 shift-and-add multiplier driving one 32-bit carry-lookahead adder per cycle.
// Define SIGNED_MULT_EN to honour Signed (magnitude capture plus a two-cycle 64-bit negation).

module cla_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  // 4-bit lookahead groups; the group carries ripple from group to group
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    logic [3:0] gg, pp;
    logic       grp_g, grp_p;
    assign gg    = g[4*gi +: 4];
    assign pp    = p[4*gi +: 4];
    assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p = &pp;
    assign c[4*gi+1] = gg[0] | (pp[0] & c[4*gi]);
    assign c[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[4*gi]);
    assign c[4*gi+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c[4*gi]);
    assign c[4*gi+4] = grp_g | (grp_p & c[4*gi]);
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
endmodule

module shift_add_multiplier_32bit #(
  parameter int WIDTH = 32
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  shift_add_multiplier_32bit_if.slave  bus
);
  if (WIDTH != 32) begin : g_width_check
    $error("shift_add_multiplier_32bit supports WIDTH=32 only");
  end

  typedef enum logic [2:0] {IDLE, RUN, NEG_LO, NEG_HI, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] mcand_reg, mcand_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] mlo_reg, mlo_next;
  logic [5:0]  count_reg, count_next;
  logic        neg_flag_reg, neg_flag_next;
  logic        signed_reg, signed_next;
  logic        carry_reg, carry_next;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        cap_signed;
  logic [31:0] cap_a, cap_b;
  logic        busy, done;

`ifdef SIGNED_MULT_EN
  assign cap_signed = bus.Signed;
`else
  assign cap_signed = 1'b0;
`endif

  // Signed operands become magnitudes; 0x80000000 negates to itself, which is the right magnitude
  assign cap_a = (cap_signed && bus.Multiplicand[31]) ? -bus.Multiplicand : bus.Multiplicand;
  assign cap_b = (cap_signed && bus.Multiplier[31])   ? -bus.Multiplier   : bus.Multiplier;

  cla_adder_32bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_reg    <= IDLE;
      mcand_reg    <= '0;
      acc_reg      <= '0;
      mlo_reg      <= '0;
      count_reg    <= '0;
      neg_flag_reg <= 1'b0;
      signed_reg   <= 1'b0;
      carry_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mcand_reg    <= mcand_next;
      acc_reg      <= acc_next;
      mlo_reg      <= mlo_next;
      count_reg    <= count_next;
      neg_flag_reg <= neg_flag_next;
      signed_reg   <= signed_next;
      carry_reg    <= carry_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mcand_next    = mcand_reg;
    acc_next      = acc_reg;
    mlo_next      = mlo_reg;
    count_next    = count_reg;
    neg_flag_next = neg_flag_reg;
    signed_next   = signed_reg;
    carry_next    = carry_reg;
    add_a         = acc_reg;
    add_b         = '0;
    add_cin       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_reg)
      RUN: begin
        busy  = 1'b1;
        add_b = mlo_reg[0] ? mcand_reg : '0;
        // 65-bit {carry, sum, mlo} shifted right; the carry becomes the new top bit
        acc_next = {add_cout, add_sum[31:1]};
        mlo_next = {add_sum[0], mlo_reg[31:1]};
        if (count_reg == 6'd31) begin
          count_next = '0;
          state_next = signed_reg ? NEG_LO : DONE;
        end else begin
          count_next = count_reg + 6'd1;
        end
      end
      NEG_LO: begin
        busy       = 1'b1;
        add_a      = neg_flag_reg ? ~mlo_reg : mlo_reg;
        add_cin    = neg_flag_reg;
        mlo_next   = add_sum;
        carry_next = add_cout;
        state_next = NEG_HI;
      end
      NEG_HI: begin
        busy       = 1'b1;
        add_a      = neg_flag_reg ? ~acc_reg : acc_reg;
        add_cin    = carry_reg;
        acc_next   = add_sum;
        state_next = DONE;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase

    // Acceptance is identical from IDLE and DONE
    if ((state_reg == IDLE || state_reg == DONE) && bus.Start) begin
      mcand_next    = cap_a;
      mlo_next      = cap_b;
      acc_next      = '0;
      count_next    = '0;
      carry_next    = 1'b0;
      signed_next   = cap_signed;
      neg_flag_next = cap_signed & (bus.Multiplicand[31] ^ bus.Multiplier[31]);
      state_next    = RUN;
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Product = {acc_reg, mlo_reg};
endmodule

// File: tb/tb_shift_add_multiplier_32bit.sv
// Directed-vector bench for shift_add_multiplier_32bit; expected products and latencies are hand-computed.
// Build with SIGNED_MULT_EN defined to exercise the signed vectors instead of the unsigned fallback.
module tb_shift_add_multiplier_32bit;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  shift_add_multiplier_32bit_if bus ();

  shift_add_multiplier_32bit #(.WIDTH(32)) dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, got);
    end
  endtask

  // Counts edges from the accepting edge (inclusive) until Done is seen
  task automatic wait_done(output int n);
    n = 1;
    while (bus.Done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.Done === 1'b1) n--;
    n = (bus.Done === 1'b1) ? n + 1 : 999;
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_p, input int exp_lat);
    int n;
    @(negedge clk);
    bus.Start = 1'b1; bus.Multiplicand = a; bus.Multiplier = b; bus.Signed = sgn;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0; bus.Multiplicand = 32'hDEADBEEF; bus.Multiplier = 32'hCAFEF00D;
    check({tag, " busy"}, {63'd0, bus.Busy}, 64'd1);
    wait_done(n);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " product"}, bus.Product, exp_p);
    @(negedge clk);
    check({tag, " held"}, {bus.Done, bus.Product[62:0]}, {1'b1, exp_p[62:0]});
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.Multiplicand = '0; bus.Multiplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", {63'd0, bus.Busy}, 64'd0);
    check("reset done", {63'd0, bus.Done}, 64'd0);
    check("reset product", bus.Product, 64'd0);
    rst_n = 1'b1;

    run_mult("ffff_sq", 32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001, 33);
    run_mult("max_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 33);
    run_mult("times_zero", 32'h12345678, 32'h00000000, 1'b0, 64'd0, 33);
    run_mult("msb_x2", 32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, 33);

    // Start held high through RUN (ignored) and across DONE (re-accept)
    @(negedge clk);
    bus.Start = 1'b1; bus.Multiplicand = 32'd9; bus.Multiplier = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.Multiplicand = 32'd7; bus.Multiplier = 32'd6;
    wait_done(n);
    check("b2b first latency", 64'(n), 64'd33);
    check("b2b first product", bus.Product, 64'd81);
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    check("b2b reaccept done", {63'd0, bus.Done}, 64'd0);
    check("b2b reaccept busy", {63'd0, bus.Busy}, 64'd1);
    wait_done(n);
    check("b2b second latency", 64'(n), 64'd33);
    check("b2b second product", bus.Product, 64'd42);

    // Reset in the middle of an operation, with Start asserted during reset
    @(negedge clk);
    bus.Start = 1'b1; bus.Multiplicand = 32'hFFFFFFFF; bus.Multiplier = 32'h00000003;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; bus.Start = 1'b1;
    @(negedge clk);
    check("midreset busy", {63'd0, bus.Busy}, 64'd0);
    check("midreset done", {63'd0, bus.Done}, 64'd0);
    check("midreset product", bus.Product, 64'd0);
    bus.Start = 1'b0;
    rst_n = 1'b1;
    run_mult("after_reset", 32'd3, 32'd5, 1'b0, 64'd15, 33);

`ifdef SIGNED_MULT_EN
    run_mult("signed_neg3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1, 35);
    run_mult("signed_min_sq", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 35);
    run_mult("signed_pos", 32'd3, 32'd5, 1'b1, 64'd15, 35);
    run_mult("signed_negxneg", 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 64'd6, 35);
    run_mult("unsigned_mode", 32'hFFFFFFFD, 32'd5, 1'b0, 64'h00000004FFFFFFF1, 33);
`else
    run_mult("signed_ignored", 32'hFFFFFFFD, 32'd5, 1'b1, 64'h00000004FFFFFFF1, 33);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
